// File: rtl/fetch_seq_ctrl.sv
// Fetch sequencer for a 2-entry halfword-aligned prefetch buffer: one-outstanding word requests,
// occupancy tracking and stale-response drop on redirect. Optional macro: FETCH_SEQ_HWORD_EN.
module fetch_seq_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            consume_i,
  input  logic            consume_comp_i,
  output logic            req_o,
  output logic [XLEN-1:0] req_addr_o,
  input  logic            ack_i,
  output logic            fill_o,
  output logic [1:0]      occ_o,
  output logic [XLEN-1:0] ip_o,
  output logic            instr_avail_o,
  output logic            stall_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      occ_q, occ_d;
  logic [XLEN-1:0] ip_q, ip_d;
  logic [XLEN-1:0] fptr_q, fptr_d;
  logic            req_q, req_d;

  logic            comp;
  logic            pc_hw;
  logic            consume_ok;
  logic            free;
  logic            pending;
  logic [XLEN-1:0] ip_step;
  logic            unused_bits;

`ifdef FETCH_SEQ_HWORD_EN
  assign comp  = consume_comp_i;
  assign pc_hw = redirect_pc_i[1];
`else
  assign comp  = 1'b0;
  assign pc_hw = 1'b0;
`endif

  assign unused_bits = ^{consume_comp_i, redirect_pc_i[1:0]};

  // A request is in flight either as a live RUN request or as the response DROP is waiting for.
  assign pending = req_q || (state_q == DROP);
  assign ip_step = comp ? XLEN'(2) : XLEN'(4);

  always_comb begin
    instr_avail_o = 1'b0;
    if (state_q != IDLE) begin
      if (!ip_q[1]) begin
        instr_avail_o = (occ_q != 2'd0);
      end else begin
        // Upper-half start: a compressed instruction fits in the current word alone.
        instr_avail_o = (occ_q == 2'd2) || ((occ_q != 2'd0) && consume_i && comp);
      end
    end
  end

  assign consume_ok = consume_i && instr_avail_o && !redirect_i;
  assign free       = consume_ok && (!comp || ip_q[1]);
  assign fill_o     = ack_i && (state_q == RUN) && !redirect_i;
  assign stall_o    = (state_q != IDLE) && !instr_avail_o && !redirect_i;

  always_comb begin
    state_d = state_q;
    occ_d   = occ_q;
    ip_d    = ip_q;
    fptr_d  = fptr_q;
    req_d   = req_q;
    if (redirect_i) begin
      occ_d  = 2'd0;
      ip_d   = {redirect_pc_i[XLEN-1:2], pc_hw, 1'b0};
      fptr_d = {redirect_pc_i[XLEN-1:2], 2'b00};
      if (pending && !ack_i) begin
        state_d = DROP;
        req_d   = 1'b0;
      end else begin
        state_d = RUN;
        req_d   = 1'b1;
      end
    end else begin
      case (state_q)
        RUN: begin
          occ_d = occ_q + {1'b0, fill_o} - {1'b0, free};
          if (consume_ok) begin
            ip_d = ip_q + ip_step;
          end
          if (fill_o) begin
            fptr_d = fptr_q + XLEN'(4);
          end
          if (!req_q || ack_i) begin
            req_d = (occ_d != 2'd2);
          end
        end
        DROP: begin
          if (ack_i) begin
            state_d = RUN;
            req_d   = (occ_q != 2'd2);
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      occ_q   <= 2'd0;
      ip_q    <= '0;
      fptr_q  <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      ip_q    <= ip_d;
      fptr_q  <= fptr_d;
      req_q   <= req_d;
    end
  end

  assign req_o      = req_q;
  assign req_addr_o = fptr_q;
  assign occ_o      = occ_q;
  assign ip_o       = ip_q;

  a_consume_legal: assert property (@(posedge clk) disable iff (!rst_n)
    !(consume_i && !instr_avail_o));

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Scoreboard bench for fetch_seq_ctrl: directed stimulus pushes expected ack outcomes,
// a monitor checks address/fill on every icache ack.
module tb_fetch_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        consume_i;
  logic        consume_comp_i;
  logic        req_o;
  logic [31:0] req_addr_o;
  logic        ack_i;
  logic        fill_o;
  logic [1:0]  occ_o;
  logic [31:0] ip_o;
  logic        instr_avail_o;
  logic        stall_o;

  logic        auto_ack;
  logic        man_ack;
  logic [31:0] stale_addr;

  typedef struct {
    logic [31:0] addr;
    logic        fill;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  assign ack_i = auto_ack ? req_o : man_ack;

  fetch_seq_ctrl #(.XLEN(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .consume_i      (consume_i),
    .consume_comp_i (consume_comp_i),
    .req_o          (req_o),
    .req_addr_o     (req_addr_o),
    .ack_i          (ack_i),
    .fill_o         (fill_o),
    .occ_o          (occ_o),
    .ip_o           (ip_o),
    .instr_avail_o  (instr_avail_o),
    .stall_o        (stall_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic f);
    exp_t e;
    e.addr = a;
    e.fill = f;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every ack seen while out of reset must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && ack_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ack_unexpected: got ack addr=0x%08h fill=%0b, expected none", req_addr_o, fill_o);
      end else begin
        mon_e = exp_q.pop_front();
        $display("ack addr=0x%08h fill=%0b (exp 0x%08h/%0b) ip=0x%08h occ=%0d",
                 req_addr_o, fill_o, mon_e.addr, mon_e.fill, ip_o, occ_o);
        chk("ack_addr", req_addr_o, mon_e.addr);
        chk("ack_fill", {31'd0, fill_o}, {31'd0, mon_e.fill});
      end
    end
  end

  initial begin
    rst_n          = 1'b0;
    redirect_i     = 1'b0;
    redirect_pc_i  = 32'd0;
    consume_i      = 1'b0;
    consume_comp_i = 1'b0;
    auto_ack       = 1'b0;
    man_ack        = 1'b0;
    stale_addr     = 32'd0;

    // Reset values
    tick();
    @(negedge clk);
    chk("rst_req", {31'd0, req_o}, 32'd0);
    chk("rst_addr", req_addr_o, 32'd0);
    chk("rst_occ", {30'd0, occ_o}, 32'd0);
    chk("rst_ip", ip_o, 32'd0);
    chk("rst_avail", {31'd0, instr_avail_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req", {31'd0, req_o}, 32'd0);
    chk("idle_stall", {31'd0, stall_o}, 32'd0);

    // Boot redirect to 0x8000_0000, zero-wait icache
    tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h8000_0000; auto_ack = 1'b1;
    push(32'h8000_0000, 1'b1);
    push(32'h8000_0004, 1'b1);
    @(negedge clk);
    chk("boot_stall_t", {31'd0, stall_o}, 32'd0);
    tick();
    redirect_i = 1'b0;
    @(negedge clk);
    chk("boot_req_t1", {31'd0, req_o}, 32'd1);
    chk("boot_avail_t1", {31'd0, instr_avail_o}, 32'd0);
    chk("boot_stall_t1", {31'd0, stall_o}, 32'd1);
    tick();
    @(negedge clk);
    chk("boot_avail_t2", {31'd0, instr_avail_o}, 32'd1);
    chk("boot_occ_t2", {30'd0, occ_o}, 32'd1);
    tick();
    @(negedge clk);
    chk("boot_occ_t3", {30'd0, occ_o}, 32'd2);
    chk("boot_req_t3", {31'd0, req_o}, 32'd0);

`ifdef FETCH_SEQ_HWORD_EN
    // Unaligned target, 32-bit instruction straddles two words
    tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h8000_0002;
    push(32'h8000_0000, 1'b1);
    push(32'h8000_0004, 1'b1);
    tick();
    redirect_i = 1'b0;
    @(negedge clk);
    chk("hw_ip", ip_o, 32'h8000_0002);
    chk("hw_avail_occ0", {31'd0, instr_avail_o}, 32'd0);
    tick();
    @(negedge clk);
    chk("hw_occ1", {30'd0, occ_o}, 32'd1);
    chk("hw_avail_occ1", {31'd0, instr_avail_o}, 32'd0);
    tick();
    consume_i = 1'b1; consume_comp_i = 1'b0;
    push(32'h8000_0008, 1'b1);
    @(negedge clk);
    chk("hw_avail_occ2", {31'd0, instr_avail_o}, 32'd1);
    tick();
    consume_i = 1'b0;
    @(negedge clk);
    chk("hw_ip_after", ip_o, 32'h8000_0006);
    chk("hw_occ_after", {30'd0, occ_o}, 32'd1);
    tick();
    auto_ack = 1'b0;
    @(negedge clk);
    chk("hw_refill_occ", {30'd0, occ_o}, 32'd2);

    // Four compressed consumes from 0x100
    tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0100; auto_ack = 1'b1;
    push(32'h0000_0100, 1'b1);
    push(32'h0000_0104, 1'b1);
    tick();
    redirect_i = 1'b0;
    tick();
    tick();
    auto_ack = 1'b0; consume_i = 1'b1; consume_comp_i = 1'b1;
    @(negedge clk);
    chk("c_ip0", ip_o, 32'h0000_0100);
    chk("c_occ0", {30'd0, occ_o}, 32'd2);
    tick();
    @(negedge clk);
    chk("c_ip1", ip_o, 32'h0000_0102);
    chk("c_occ1", {30'd0, occ_o}, 32'd2);
    tick();
    @(negedge clk);
    chk("c_ip2", ip_o, 32'h0000_0104);
    chk("c_occ2", {30'd0, occ_o}, 32'd1);
    tick();
    @(negedge clk);
    chk("c_ip3", ip_o, 32'h0000_0106);
    chk("c_occ3", {30'd0, occ_o}, 32'd1);
    chk("c_avail_comp_hi", {31'd0, instr_avail_o}, 32'd1);
    tick();
    consume_i = 1'b0; consume_comp_i = 1'b0;
    @(negedge clk);
    chk("c_ip4", ip_o, 32'h0000_0108);
    chk("c_occ4", {30'd0, occ_o}, 32'd0);
    chk("c_avail4", {31'd0, instr_avail_o}, 32'd0);
    chk("c_stall4", {31'd0, stall_o}, 32'd1);
    chk("c_req4", {31'd0, req_o}, 32'd1);
    chk("c_addr4", req_addr_o, 32'h0000_0108);
    stale_addr = 32'h0000_0108;
`else
    // Halfword features off: 0x302 lands on 0x300, every consume is a full word
    tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0302;
    push(32'h0000_0300, 1'b1);
    push(32'h0000_0304, 1'b1);
    tick();
    redirect_i = 1'b0;
    @(negedge clk);
    chk("w_ip", ip_o, 32'h0000_0300);
    chk("w_addr", req_addr_o, 32'h0000_0300);
    tick();
    @(negedge clk);
    chk("w_avail", {31'd0, instr_avail_o}, 32'd1);
    chk("w_occ1", {30'd0, occ_o}, 32'd1);
    tick();
    auto_ack = 1'b0; consume_i = 1'b1; consume_comp_i = 1'b1;
    @(negedge clk);
    chk("w_occ2", {30'd0, occ_o}, 32'd2);
    tick();
    @(negedge clk);
    chk("w_ip1", ip_o, 32'h0000_0304);
    chk("w_occ_c1", {30'd0, occ_o}, 32'd1);
    chk("w_req", {31'd0, req_o}, 32'd1);
    chk("w_req_addr", req_addr_o, 32'h0000_0308);
    tick();
    consume_i = 1'b0; consume_comp_i = 1'b0;
    @(negedge clk);
    chk("w_ip2", ip_o, 32'h0000_0308);
    chk("w_occ_c2", {30'd0, occ_o}, 32'd0);
    chk("w_avail0", {31'd0, instr_avail_o}, 32'd0);
    chk("w_stall", {31'd0, stall_o}, 32'd1);
    stale_addr = 32'h0000_0308;
`endif

    // Redirect coinciding with ack: stale, no DROP
    tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0100; man_ack = 1'b1;
    push(stale_addr, 1'b0);
    @(negedge clk);
    chk("rdack_stall", {31'd0, stall_o}, 32'd0);
    tick();
    redirect_i = 1'b0;
    push(32'h0000_0100, 1'b1);
    @(negedge clk);
    chk("rdack_req_t1", {31'd0, req_o}, 32'd1);
    chk("rdack_addr_t1", req_addr_o, 32'h0000_0100);
    tick();
    man_ack = 1'b0;
    @(negedge clk);
    chk("hold_addr_a", req_addr_o, 32'h0000_0104);
    chk("hold_occ", {30'd0, occ_o}, 32'd1);
    tick();
    @(negedge clk);
    chk("hold_req_b", {31'd0, req_o}, 32'd1);
    chk("hold_addr_b", req_addr_o, 32'h0000_0104);

    // Redirect with 0x104 outstanding, stale ack two cycles later
    tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200;
    tick();
    redirect_i = 1'b0;
    @(negedge clk);
    chk("drop_req", {31'd0, req_o}, 32'd0);
    chk("drop_occ", {30'd0, occ_o}, 32'd0);
    tick();
    man_ack = 1'b1;
    push(32'h0000_0200, 1'b0);
    tick();
    push(32'h0000_0200, 1'b1);
    @(negedge clk);
    chk("drop_req_after", {31'd0, req_o}, 32'd1);
    chk("drop_addr_after", req_addr_o, 32'h0000_0200);
    tick();
    man_ack = 1'b0;
    @(negedge clk);
    chk("drop_occ_after", {30'd0, occ_o}, 32'd1);

    // Reset mid-operation, then an ack in IDLE must be ignored
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, req_o}, 32'd0);
    chk("mid_rst_addr", req_addr_o, 32'd0);
    chk("mid_rst_occ", {30'd0, occ_o}, 32'd0);
    chk("mid_rst_ip", ip_o, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    man_ack = 1'b1;
    push(32'd0, 1'b0);
    tick();
    man_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_occ", {30'd0, occ_o}, 32'd0);
    chk("idle_ack_req", {31'd0, req_o}, 32'd0);

    tick();
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
